keccak_padder: RTL and testbench

KECCAK_PADDER -- requirements
Module: keccak_padder

---
 rtl/keccak_padder.sv | 175 +++++++++++++++++
 tb/tb_keccak_padder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_padder.sv
// Keccak/SHA-3 message padder.
// Packs 64-bit message words into rate-sized absorb blocks, applies the
// domain suffix plus the final 0x80 pad bit, and hands each block to the
// permutation core through a valid/ready handshake.
module keccak_padder (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    input  logic [2:0]    cmode,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [1343:0] blk_data,
    output logic [4:0]    blk_lanes,
    output logic          blk_last,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, PADBLK} state_t;

    state_t            state, state_next;
    logic [4:0]        lane_cnt, lane_cnt_next;
    logic [2:0]        mode, mode_next;
    logic              last_flag, last_flag_next;
    logic              pad_pending, pad_pending_next;
    logic [20:0][63:0] blk_buf, blk_buf_next;

    logic              accept;
    logic [2:0]        cur_mode;
    logic [4:0]        rate;
    logic [4:0]        rate_m1;
    logic [7:0]        suffix;
    logic [4:0]        idx;
    logic [3:0]        nb;
    logic              split;
    logic [7:0]        sfx_pos;
    logic [63:0]       byte_mask;

    // Rate in 64-bit lanes for each hash mode; unknown modes fall back to SHA3-256.
    function automatic logic [4:0] rate_of(input logic [2:0] m);
        case (m)
            3'd0:    rate_of = 5'd18;
            3'd1:    rate_of = 5'd17;
            3'd2:    rate_of = 5'd13;
            3'd3:    rate_of = 5'd9;
            3'd4:    rate_of = 5'd21;
            default: rate_of = 5'd17;
        endcase
    endfunction

    // Domain-separation suffix: SHAKE modes use 0x1F, SHA-3 modes 0x06.
    function automatic logic [7:0] suffix_of(input logic [2:0] m);
        suffix_of = (m == 3'd4 || m == 3'd5) ? 8'h1F : 8'h06;
    endfunction

    // Word-level decode: which mode/rate applies to the word on the bus and
    // where its padding lands inside the block.
    always_comb begin
        accept   = in_valid && in_ready;
        cur_mode = (state == IDLE) ? cmode : mode;
        rate     = rate_of(cur_mode);
        rate_m1  = rate - 5'd1;
        suffix   = suffix_of(cur_mode);
        idx      = (state == IDLE) ? 5'd0 : lane_cnt;
        nb       = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        // A full final word that closes the block leaves no room for padding.
        split    = (nb == 4'd8) && (idx == rate_m1);
        sfx_pos  = {idx, 3'b000} + {4'b0000, nb};
        byte_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < nb) byte_mask[8*k +: 8] = 8'hFF;
        end
    end

    // Control state register; the whole padder returns to IDLE on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lane_cnt    <= 5'd0;
            mode        <= 3'd1;
            last_flag   <= 1'b0;
            pad_pending <= 1'b0;
        end else begin
            state       <= state_next;
            lane_cnt    <= lane_cnt_next;
            mode        <= mode_next;
            last_flag   <= last_flag_next;
            pad_pending <= pad_pending_next;
        end
    end

    // Block buffer register; cleared on reset so a partial message is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) blk_buf <= '0;
        else     blk_buf <= blk_buf_next;
    end

    // Next-state and buffer update: absorb words, pad the final one, and
    // clear or preload the buffer on each block handshake.
    always_comb begin
        state_next       = state;
        lane_cnt_next    = lane_cnt;
        mode_next        = mode;
        last_flag_next   = last_flag;
        pad_pending_next = pad_pending;
        blk_buf_next     = blk_buf;
        case (state)
            IDLE, FILL: begin
                if (accept) begin
                    if (state == IDLE) mode_next = cmode;
                    for (int i = 0; i < 21; i++) begin
                        if (5'(i) == idx)
                            blk_buf_next[i] = in_last ? (in_data & byte_mask) : in_data;
                        if (in_last && !split) begin
                            if (5'(i) == sfx_pos[7:3])
                                blk_buf_next[i] = blk_buf_next[i] ^ (64'(suffix) << {sfx_pos[2:0], 3'b000});
                            if (5'(i) == rate_m1)
                                blk_buf_next[i][63:56] = blk_buf_next[i][63:56] ^ 8'h80;
                        end
                    end
                    if (in_last) begin
                        state_next       = EMIT;
                        last_flag_next   = !split;
                        pad_pending_next = split;
                    end else if (idx == rate_m1) begin
                        state_next = EMIT;
                    end else begin
                        state_next    = FILL;
                        lane_cnt_next = idx + 5'd1;
                    end
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    blk_buf_next   = '0;
                    lane_cnt_next  = 5'd0;
                    last_flag_next = 1'b0;
                    if (pad_pending) begin
                        // Preload the padding-only block shown in PADBLK.
                        state_next                  = PADBLK;
                        pad_pending_next            = 1'b0;
                        blk_buf_next[0][7:0]        = suffix;
                        blk_buf_next[rate_m1][63:56] = blk_buf_next[rate_m1][63:56] ^ 8'h80;
                    end else if (last_flag) begin
                        state_next = IDLE;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            PADBLK: begin
                if (blk_ready) begin
                    blk_buf_next  = '0;
                    lane_cnt_next = 5'd0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only (blk_ready never feeds blk_valid).
    always_comb begin
        in_ready  = !rst && (state == IDLE || state == FILL);
        blk_valid = (state == EMIT) || (state == PADBLK);
        blk_last  = (state == PADBLK) || (state == EMIT && last_flag);
        busy      = (state != IDLE);
        blk_lanes = rate_of(mode);
        blk_data  = blk_buf;
    end

endmodule

// File: tb/tb_keccak_padder.sv
// Testbench for keccak_padder: directed vector table, hand-written
// backpressure / reset sequences, and randomized messages checked against
// a byte-level padding model.
module tb_keccak_padder;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = '0;
    logic [2:0]    cmode = '0;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic [1343:0] blk_data;
    logic [4:0]    blk_lanes;
    logic          blk_last;
    logic          busy;

    keccak_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .cmode     (cmode),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_lanes (blk_lanes),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1343:0] data;
        logic [4:0]    lanes;
        logic          last;
    } blk_t;

    typedef struct {
        logic [2:0]  mode;
        int          nfull;
        logic [3:0]  nb;
        logic [63:0] last_word;
        int          exp_blocks;
        logic [63:0] exp_lane0;
        logic [63:0] exp_top;
        logic [4:0]  exp_lanes;
    } vec_t;

    localparam logic [63:0] F = 64'h1111_2222_3333_4444;
    localparam logic [63:0] TOP80 = 64'h8000_0000_0000_0000;

    int          n_tests = 0;
    int          n_fail = 0;
    blk_t        got_q[$];
    blk_t        exp_q[$];
    logic [63:0] word_q[$];
    logic [7:0]  msg_q[$];
    bit          hold_ready = 1'b0;
    bit          rand_ready = 1'b0;
    int          rate_tab[8] = '{18, 17, 13, 9, 21, 17, 17, 17};

    // Downstream sink: drives blk_ready and records each block that will
    // handshake on the coming rising edge.
    always @(negedge clk) begin
        if (hold_ready)      blk_ready = 1'b0;
        else if (rand_ready) blk_ready = ($urandom_range(0, 2) != 0);
        else                 blk_ready = 1'b1;
        if (blk_valid && blk_ready && !rst)
            got_q.push_back('{blk_data, blk_lanes, blk_last});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests expected completion", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_blk(input string name, input blk_t g, input blk_t e);
        int d;
        d = -1;
        n_tests++;
        if (g.data !== e.data || g.lanes !== e.lanes || g.last !== e.last) begin
            n_fail++;
            for (int i = 0; i < 21; i++)
                if (d < 0 && g.data[64*i +: 64] !== e.data[64*i +: 64]) d = i;
            if (d < 0) d = 0;
            $display("FAIL %s: lane %0d got %h expected %h, lanes got %0d expected %0d, last got %0b expected %0b",
                     name, d, g.data[64*d +: 64], e.data[64*d +: 64], g.lanes, e.lanes, g.last, e.last);
        end
    endtask

    // Reference: append suffix, zero-fill to a multiple of the rate, set
    // the top bit of the final byte, then cut into blocks.
    task automatic build_exp(input logic [2:0] mode);
        int         rate;
        int         rb;
        int         nblk;
        logic [7:0] p[$];
        blk_t       e;
        rate = rate_tab[mode];
        rb   = rate * 8;
        p    = msg_q;
        p.push_back((mode == 3'd4 || mode == 3'd5) ? 8'h1F : 8'h06);
        while ((p.size() % rb) != 0) p.push_back(8'h00);
        p[p.size() - 1] = p[p.size() - 1] ^ 8'h80;
        nblk = p.size() / rb;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            e.data  = '0;
            for (int j = 0; j < rb; j++) e.data[8*j +: 8] = p[b*rb + j];
            e.lanes = 5'(rate);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    // Present one word (caller sits on a falling edge) and hold it until accepted.
    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb, input logic [2:0] m);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        cmode    = m;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_word: in_ready got 0 expected 1 within %0d cycles", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send word_q as one message and compare every produced block with the model.
    task automatic run_msg(input logic [2:0] mode, input logic [3:0] nb_raw);
        int n;
        int lb;
        int t;
        n  = word_q.size();
        lb = (nb_raw > 4'd8) ? 8 : int'(nb_raw);
        msg_q.delete();
        for (int i = 0; i < n - 1; i++)
            for (int k = 0; k < 8; k++) msg_q.push_back(word_q[i][8*k +: 8]);
        for (int k = 0; k < lb; k++) msg_q.push_back(word_q[n-1][8*k +: 8]);
        build_exp(mode);
        got_q.delete();
        for (int i = 0; i < n; i++)
            send_word(word_q[i], (i == n - 1), (i == n - 1) ? nb_raw : 4'($urandom),
                      (i == 0) ? mode : 3'($urandom));
        t = 0;
        while (got_q.size() < exp_q.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("block_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk_blk("block_model", got_q[i], exp_q[i]);
        chk("busy_after_msg", 64'(busy), 64'(0));
    endtask

    initial begin
        vec_t          vt[9];
        logic [1343:0] snap;
        bit            stable;
        int            t;
        logic [2:0]    rmode;
        int            rnfull;
        logic [3:0]    rnb;

        vt[0] = '{3'd1, 0,  4'd0,  64'hDEAD_BEEF_CAFE_F00D, 1, 64'h06, TOP80, 5'd17};
        vt[1] = '{3'd1, 0,  4'd3,  64'h0000_0000_0063_6261, 1, 64'h0000_0000_0663_6261, TOP80, 5'd17};
        vt[2] = '{3'd3, 8,  4'd8,  F, 2, 64'h06, TOP80, 5'd9};
        vt[3] = '{3'd4, 20, 4'd7,  64'hFFEE_DDCC_BBAA_9988, 1, F, 64'h9FEE_DDCC_BBAA_9988, 5'd21};
        vt[4] = '{3'd7, 0,  4'd8,  F, 1, F, TOP80, 5'd17};
        vt[5] = '{3'd4, 0,  4'd0,  F, 1, 64'h1F, TOP80, 5'd21};
        vt[6] = '{3'd3, 8,  4'd7,  F, 1, F, 64'h8611_2222_3333_4444, 5'd9};
        vt[7] = '{3'd2, 0,  4'd12, F, 1, F, TOP80, 5'd13};
        vt[8] = '{3'd5, 16, 4'd8,  F, 2, 64'h1F, TOP80, 5'd17};

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_blk_valid", 64'(blk_valid), 64'(0));
        chk("rst_blk_last",  64'(blk_last),  64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_blk_lanes", 64'(blk_lanes), 64'(17));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Directed vector table
        for (int v = 0; v < 9; v++) begin
            word_q.delete();
            for (int i = 0; i < vt[v].nfull; i++) word_q.push_back(F);
            word_q.push_back(vt[v].last_word);
            run_msg(vt[v].mode, vt[v].nb);
            chk($sformatf("vec%0d_blocks", v), 64'(got_q.size()), 64'(vt[v].exp_blocks));
            if (got_q.size() > 0) begin
                chk($sformatf("vec%0d_lane0", v), got_q[$].data[63:0], vt[v].exp_lane0);
                chk($sformatf("vec%0d_top", v),
                    got_q[$].data[64*(int'(vt[v].exp_lanes) - 1) +: 64], vt[v].exp_top);
                chk($sformatf("vec%0d_lanes", v), 64'(got_q[$].lanes), 64'(vt[v].exp_lanes));
                chk($sformatf("vec%0d_last", v), 64'(got_q[$].last), 64'(1));
            end else begin
                n_tests++;
                n_fail++;
                $display("FAIL vec%0d_final: got no block expected %0d", v, vt[v].exp_blocks);
            end
        end

        // Randomized messages with random downstream stalls
        rand_ready = 1'b1;
        for (int r = 0; r < 25; r++) begin
            rmode  = 3'($urandom_range(0, 7));
            rnfull = $urandom_range(0, 45);
            rnb    = 4'($urandom_range(0, 15));
            word_q.delete();
            for (int i = 0; i <= rnfull; i++) word_q.push_back({$urandom, $urandom});
            run_msg(rmode, rnb);
        end
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure: hold blk_ready low for 10 cycles in EMIT
        hold_ready = 1'b1;
        repeat (2) @(negedge clk);
        got_q.delete();
        send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3, 3'd1);
        chk("latency_one_cycle", 64'(blk_valid), 64'(1));
        snap   = blk_data;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (blk_data !== snap || in_ready !== 1'b0 || blk_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'(1));
        chk("bp_no_handshake", 64'(got_q.size()), 64'(0));
        chk("bp_lane0", snap[63:0], 64'h0000_0000_0663_6261);
        chk("bp_lane16", snap[64*16 +: 64], TOP80);
        hold_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_one_handshake", 64'(got_q.size()), 64'(1));
        chk("bp_valid_drop", 64'(blk_valid), 64'(0));

        // Reset in the middle of FILL
        for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b0, 4'd0, 3'd1);
        chk("fill_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_busy",      64'(busy),      64'(0));
        chk("midrst_blk_valid", 64'(blk_valid), 64'(0));
        chk("midrst_in_ready",  64'(in_ready),  64'(0));
        chk("midrst_blk_lanes", 64'(blk_lanes), 64'(17));
        chk("midrst_buf_lane0", blk_data[63:0], 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 64'(in_ready), 64'(1));
        @(negedge clk);
        word_q.delete();
        word_q.push_back(F);
        word_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        run_msg(3'd1, 4'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
